// File: rtl/requant_pkg.sv
// Shared definitions for the requantiser: default widths, output clamp
// limits and the normalisation helpers used by every lane.
// Optional feature macro: REQUANT_ZERO_POINT_EN (adds an output zero point).
package requant_pkg;

    localparam int DN_DEF   = 6;   // lanes
    localparam int DW_DEF   = 22;  // accumulator width
    localparam int MULW_DEF = 9;   // mantissa / multiplier width
    localparam int OW_DEF   = 8;   // activation width
    localparam int SFTW_DEF = 5;   // layer shift field width

    // Clamp limits of a signed OW_DEF-bit activation.
    localparam int SAT_MAX = (1 << (OW_DEF - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OW_DEF - 1));

    // Number of consecutive bits directly below the MSB that equal the MSB.
    function automatic int lead_sign_count(input logic [63:0] acc, input int dw);
        int   lead;
        logic run;
        lead = 0;
        run  = 1'b1;
        for (int i = 62; i >= 0; i--) begin
            if (i <= dw - 2) begin
                if (run && (acc[i] == acc[dw-1])) lead++;
                else run = 1'b0;
            end
        end
        return lead;
    endfunction

    // Bit position of the mantissa window: max(0, dw - mulw - lead).
    function automatic int norm_pos(input logic [63:0] acc, input int dw, input int mulw);
        int p;
        p = dw - mulw - lead_sign_count(acc, dw);
        return (p < 0) ? 0 : p;
    endfunction

endpackage

// File: rtl/requant_if.sv
// Accumulator-in / activation-out stream bundle with valid/ready on both
// sides. The slave modport is the requantiser's view, master the producer's
// and consumer's. Optional feature macro: REQUANT_ZERO_POINT_EN (out_zp).
interface requant_if
    import requant_pkg::*;
#(
    parameter int DN   = DN_DEF,
    parameter int DW   = DW_DEF,
    parameter int MULW = MULW_DEF,
    parameter int OW   = OW_DEF,
    parameter int SFTW = SFTW_DEF
);

    logic               in_valid;
    logic               in_ready;
    logic [DN*DW-1:0]   in_data;
    logic [DN*MULW-1:0] in_mult;
    logic [SFTW-1:0]    in_shift;
    logic               relu_en;
`ifdef REQUANT_ZERO_POINT_EN
    logic [OW-1:0]      out_zp;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [DN*OW-1:0]   out_data;

    modport slave (
        input  in_valid, in_data, in_mult, in_shift, relu_en, out_ready,
`ifdef REQUANT_ZERO_POINT_EN
        input  out_zp,
`endif
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_mult, in_shift, relu_en, out_ready,
`ifdef REQUANT_ZERO_POINT_EN
        output out_zp,
`endif
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/requant_lane.sv
// One channel of the requantiser: S1 normalise, S2 multiply,
// S3 shift/round/saturate/ReLU into the output register. All stages move
// together on adv; valid tracking lives in the parent.
// Optional feature macro: REQUANT_ZERO_POINT_EN (zero point added after ReLU).
module requant_lane
    import requant_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int MULW = MULW_DEF,
    parameter int OW   = OW_DEF,
    parameter int SFTW = SFTW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   adv,
    input  logic signed [DW-1:0]   acc,
    input  logic signed [MULW-1:0] mult,
    input  logic [SFTW-1:0]        shift,
    input  logic                   relu_en,
`ifdef REQUANT_ZERO_POINT_EN
    input  logic signed [OW-1:0]   zp,
`endif
    output logic signed [OW-1:0]   res
);

    localparam int EW   = SFTW + 2;          // signed exponent e = n - p
    localparam int PW   = 2 * MULW;          // exact product width
    localparam int RW_A = MULW + DW + 2;     // room for the largest left shift
    localparam int RW_B = (1 << SFTW) + 2;   // room for the largest round constant
    localparam int RW   = (RW_A > RW_B) ? RW_A : RW_B;

    localparam logic signed [RW-1:0] SMAX_W = (RW'(1) <<< (OW - 1)) - RW'(1);
    localparam logic signed [RW-1:0] SMIN_W = -(RW'(1) <<< (OW - 1));

    int                     p_pos;
    logic signed [MULW-1:0] mant_d;
    logic signed [EW-1:0]   e_d;

    logic signed [MULW-1:0] s1_mant, s1_mult;
    logic signed [EW-1:0]   s1_e;
    logic                   s1_relu;
    logic signed [PW-1:0]   s2_p;
    logic signed [EW-1:0]   s2_e;
    logic                   s2_relu;
`ifdef REQUANT_ZERO_POINT_EN
    logic signed [OW-1:0]   s1_zp, s2_zp;
    logic signed [OW:0]     zsum;
`endif

    logic signed [RW-1:0]   p_w, r;
    logic signed [OW-1:0]   clamped, post, res_d;

    // Normalise: pick the MULW-bit window just below the redundant sign bits.
    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        p_pos  = norm_pos(64'(acc), DW, MULW);
        mant_d = acc[p_pos +: MULW];
        e_d    = $signed({2'b00, shift}) - EW'(p_pos);
    end

    // Pipeline registers S1, S2 and the output register, all gated by adv.
    // NOTE: non-blocking assignments so each stage captures the pre-edge value of the one before.
    // NOTE: the datapath registers are reset as well, so the output reads 0 straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_mant <= '0;
            s1_mult <= '0;
            s1_e    <= '0;
            s1_relu <= 1'b0;
            s2_p    <= '0;
            s2_e    <= '0;
            s2_relu <= 1'b0;
            res     <= '0;
`ifdef REQUANT_ZERO_POINT_EN
            s1_zp   <= '0;
            s2_zp   <= '0;
`endif
        end else if (adv) begin
            s1_mant <= mant_d;
            s1_mult <= mult;
            s1_e    <= e_d;
            s1_relu <= relu_en;
            s2_p    <= s1_mant * s1_mult;
            s2_e    <= s1_e;
            s2_relu <= s1_relu;
            res     <= res_d;
`ifdef REQUANT_ZERO_POINT_EN
            s1_zp   <= zp;
            s2_zp   <= s1_zp;
`endif
        end
    end

    // Shift with half-up rounding at a width where neither the round carry
    // nor a left shift can overflow, then clamp, ReLU and zero point.
    always_comb begin
        p_w = RW'(s2_p);
        r   = p_w;
        if (s2_e > 0) begin
            r = (p_w + (RW'(1) <<< (s2_e - EW'(1)))) >>> s2_e;
        end else if (s2_e < 0) begin
            r = p_w <<< (-s2_e);
        end

        if (r > SMAX_W)      clamped = SMAX_W[OW-1:0];
        else if (r < SMIN_W) clamped = SMIN_W[OW-1:0];
        else                 clamped = r[OW-1:0];

        post = (s2_relu && clamped[OW-1]) ? '0 : clamped;

`ifdef REQUANT_ZERO_POINT_EN
        zsum = {post[OW-1], post} + {s2_zp[OW-1], s2_zp};
        if (zsum[OW] != zsum[OW-1]) res_d = zsum[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else                        res_d = zsum[OW-1:0];
`else
        res_d = post;
`endif
    end

endmodule

// File: rtl/requant_pipe.sv
// Per-channel requantiser, DN lanes of DW-bit accumulators to OW-bit
// activations, three register stages with a single global advance enable.
// Optional feature macro: REQUANT_ZERO_POINT_EN (adds out_zp to the bus).
module requant_pipe
    import requant_pkg::*;
#(
    parameter int DN   = DN_DEF,
    parameter int DW   = DW_DEF,
    parameter int MULW = MULW_DEF,
    parameter int OW   = OW_DEF,
    parameter int SFTW = SFTW_DEF
) (
    input logic       clk,
    input logic       rst_n,
    requant_if.slave  bus
);

    logic             adv;
    logic             s1_valid, s2_valid, out_valid_q;
    logic [DN*OW-1:0] out_data_w;

    // The whole pipe moves whenever the output slot is empty or being taken.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_w;

    // Valid bits travel alongside the lane datapath; bubbles stay invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
        end
    end

    for (genvar i = 0; i < DN; i++) begin : g_lane
        requant_lane #(
            .DW   (DW),
            .MULW (MULW),
            .OW   (OW),
            .SFTW (SFTW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .acc     (bus.in_data[i*DW +: DW]),
            .mult    (bus.in_mult[i*MULW +: MULW]),
            .shift   (bus.in_shift),
            .relu_en (bus.relu_en),
`ifdef REQUANT_ZERO_POINT_EN
            .zp      (bus.out_zp),
`endif
            .res     (out_data_w[i*OW +: OW])
        );
    end

endmodule
